reg_byte_unloader: RTL and testbench

- Read-side counterpart to the parallel-load registers.
- Captures a 32-bit register value in one cycle and unloads it as NBYTES bytes on an 8-bit bus, MSB byte first.
- Each byte is presented under a Valid/Ack handshake.
- Feeds the byte-wide I/O path of the MiniComputer datapath; the register writer side uses the same Data/Ld/Init control style.

---
 rtl/reg_byte_unloader.sv | 98 +++++++++
 tb/tb_reg_byte_unloader.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_byte_unloader.sv
//------------------------------------------------------------------------------
// Module  : reg_byte_unloader
// Purpose : Captures an 8*NBYTES-bit word and unloads it MSB byte first under
//           a Valid/Ack handshake on an 8-bit bus.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module reg_byte_unloader #(
    parameter int NBYTES = 4
) (
    input  logic                        Clk,
    input  logic                        Rst,
    input  logic [8*NBYTES-1:0]         Data,
    input  logic                        Ld,
    input  logic                        Init,
    input  logic                        Ack,
    output logic [7:0]                  Byte,
    output logic                        Valid,
    output logic [$clog2(NBYTES)-1:0]   Idx,
    output logic                        Busy,
    output logic                        Done
);

    localparam int                 WORD_W = 8 * NBYTES;
    localparam int                 IDX_W  = $clog2(NBYTES);
    localparam logic [IDX_W-1:0]   LAST   = IDX_W'(NBYTES - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t              state;
    logic [WORD_W-1:0]   sr;

    // The presented byte is always the top of the shift register, which is
    // zeroed whenever nothing is in flight, so Byte reads 00 outside SEND.
    assign Byte = sr[WORD_W-1 -: 8];

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state <= ST_IDLE;
            sr    <= '0;
            Idx   <= '0;
            Valid <= 1'b0;
            Busy  <= 1'b0;
            Done  <= 1'b0;
        end else begin
            Done <= 1'b0;
            if (Init) begin
                // Abort drops any partially sent word without a Done pulse.
                state <= ST_IDLE;
                sr    <= '0;
                Idx   <= '0;
                Valid <= 1'b0;
                Busy  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (Ld) begin
                            sr    <= Data;
                            Idx   <= '0;
                            Valid <= 1'b1;
                            Busy  <= 1'b1;
                            state <= ST_SEND;
                        end
                    end
                    ST_SEND: begin
                        if (Ack) begin
                            if (Idx == LAST) begin
                                sr    <= '0;
                                Idx   <= '0;
                                Valid <= 1'b0;
                                Busy  <= 1'b0;
                                Done  <= 1'b1;
                                state <= ST_IDLE;
                            end else begin
                                sr  <= {sr[WORD_W-9:0], 8'h00};
                                Idx <= Idx + IDX_W'(1);
                            end
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        sr    <= '0;
                        Idx   <= '0;
                        Valid <= 1'b0;
                        Busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_reg_byte_unloader.sv
//------------------------------------------------------------------------------
// Module  : tb_reg_byte_unloader
// Purpose : Self-checking bench for reg_byte_unloader (NBYTES=4).
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_reg_byte_unloader;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic [31:0] Data = '0;
    logic        Ld = 1'b0;
    logic        Init = 1'b0;
    logic        Ack = 1'b0;
    logic [7:0]  Byte;
    logic        Valid;
    logic [1:0]  Idx;
    logic        Busy;
    logic        Done;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [7:0] exp_q[$];

    typedef struct {
        logic [31:0]     data;
        int              stall_first;
        int              stall_rest;
        logic [3:0][7:0] exp;
    } vec_t;

    vec_t vecs[3];

    reg_byte_unloader #(.NBYTES(4)) dut (
        .Clk   (Clk),
        .Rst   (Rst),
        .Data  (Data),
        .Ld    (Ld),
        .Init  (Init),
        .Ack   (Ack),
        .Byte  (Byte),
        .Valid (Valid),
        .Idx   (Idx),
        .Busy  (Busy),
        .Done  (Done)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_idle(input string name);
        chk({name, " valid"}, {31'd0, Valid}, 32'd0);
        chk({name, " busy"},  {31'd0, Busy},  32'd0);
        chk({name, " byte"},  {24'd0, Byte},  32'd0);
        chk({name, " idx"},   {30'd0, Idx},   32'd0);
    endtask

    // Compare the currently presented byte against the scoreboard head.
    task automatic pop_chk(input int i);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            chk("scoreboard underflow", 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        chk("valid", {31'd0, Valid}, 32'd1);
        chk("busy",  {31'd0, Busy},  32'd1);
        chk("byte",  {24'd0, Byte},  {24'd0, e});
        chk("idx",   {30'd0, Idx},   i[31:0]);
    endtask

    // Load a word and drain it; returns in the cycle where Done should be high.
    task automatic unload_word(input logic [31:0] d, input logic [3:0][7:0] e,
                               input int stall_first, input int stall_rest,
                               input bit junk_ld);
        Ld   = 1'b1;
        Data = d;
        Ack  = 1'b0;
        for (int b = 3; b >= 0; b--) exp_q.push_back(e[b]);
        cyc();
        Ld = junk_ld;
        if (junk_ld) Data = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            int s;
            s = (i == 0) ? stall_first : stall_rest;
            if (s > 0) begin
                Ack = 1'b0;
                for (int k = 0; k < s; k++) begin
                    chk("stall valid", {31'd0, Valid}, 32'd1);
                    chk("stall byte", {24'd0, Byte}, {24'd0, exp_q[0]});
                    cyc();
                end
            end
            pop_chk(i);
            chk("no early done", {31'd0, Done}, 32'd0);
            Ack = 1'b1;
            cyc();
        end
        Ack = 1'b0;
        Ld  = 1'b0;
        chk("done pulse", {31'd0, Done}, 32'd1);
        chk_idle("after last");
    endtask

    initial begin
        vecs[0] = '{data: 32'hDEAD_BEEF, stall_first: 0, stall_rest: 0,
                    exp: {8'hDE, 8'hAD, 8'hBE, 8'hEF}};
        vecs[1] = '{data: 32'h1234_5678, stall_first: 5, stall_rest: 1,
                    exp: {8'h12, 8'h34, 8'h56, 8'h78}};
        vecs[2] = '{data: 32'h00FF_8001, stall_first: 2, stall_rest: 3,
                    exp: {8'h00, 8'hFF, 8'h80, 8'h01}};

        // Asynchronous reset takes effect before any clock edge.
        #1 Rst = 1'b1;
        #1;
        chk_idle("reset");
        chk("reset done", {31'd0, Done}, 32'd0);
        cyc();
        cyc();
        Rst = 1'b0;
        cyc();
        chk_idle("post reset");

        // Table-driven unloads.
        for (int v = 0; v < 3; v++) begin
            unload_word(vecs[v].data, vecs[v].exp, vecs[v].stall_first,
                        vecs[v].stall_rest, 1'b0);
            cyc();
            chk("done one cycle", {31'd0, Done}, 32'd0);
        end

        // Ld during SEND is ignored; Ld in the Done cycle is accepted.
        unload_word(32'hA5A5_A5A5, {8'hA5, 8'hA5, 8'hA5, 8'hA5}, 0, 0, 1'b1);
        unload_word(32'h0102_0304, {8'h01, 8'h02, 8'h03, 8'h04}, 0, 1, 1'b0);
        cyc();
        chk("done drop", {31'd0, Done}, 32'd0);

        // Abort after two bytes accepted.
        Ld = 1'b1;
        Data = 32'hCAFE_F00D;
        for (int b = 3; b >= 0; b--) exp_q.push_back(Data[8*b +: 8]);
        cyc();
        Ld = 1'b0;
        pop_chk(0);
        Ack = 1'b1;
        cyc();
        pop_chk(1);
        cyc();
        Ack = 1'b0;
        chk("pre-abort byte", {24'd0, Byte}, 32'h0000_00F0);
        Init = 1'b1;
        cyc();
        Init = 1'b0;
        exp_q.delete();
        chk_idle("abort");
        chk("abort done", {31'd0, Done}, 32'd0);
        cyc();
        chk("abort done later", {31'd0, Done}, 32'd0);
        unload_word(32'h0BAD_C0DE, {8'h0B, 8'hAD, 8'hC0, 8'hDE}, 1, 0, 1'b0);
        cyc();

        // Init and Ld together in IDLE: stays idle.
        Init = 1'b1;
        Ld   = 1'b1;
        Data = 32'h5555_AAAA;
        cyc();
        Init = 1'b0;
        Ld   = 1'b0;
        chk_idle("init+ld");
        cyc();
        chk_idle("init+ld later");

        // Init with the final Ack: no Done pulse.
        Ld = 1'b1;
        Data = 32'h1122_3344;
        for (int b = 3; b >= 0; b--) exp_q.push_back(Data[8*b +: 8]);
        cyc();
        Ld  = 1'b0;
        Ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pop_chk(i);
            cyc();
        end
        pop_chk(3);
        Init = 1'b1;
        cyc();
        Init = 1'b0;
        Ack  = 1'b0;
        chk("init+final done", {31'd0, Done}, 32'd0);
        chk_idle("init+final");
        cyc();
        chk("init+final done later", {31'd0, Done}, 32'd0);

        // Reset in the middle of SEND clears outputs immediately.
        Ld = 1'b1;
        Data = 32'h7777_8888;
        cyc();
        Ld = 1'b0;
        chk("pre-reset valid", {31'd0, Valid}, 32'd1);
        chk("pre-reset byte", {24'd0, Byte}, 32'h0000_0077);
        #2 Rst = 1'b1;
        #1;
        chk_idle("mid reset");
        cyc();
        Rst = 1'b0;
        cyc();
        chk_idle("post mid reset");

        chk("scoreboard empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

`default_nettype wire
